// File: rtl/decode_seq.sv
// Instruction decoder / issue sequencer: one 16-bit fetch word in, one registered control word out.
// Latency: a word accepted at edge N drives its control word in cycle N+1.
// Backpressure: inst_ready drops while an LPM, branch resolve or flush sequence is in flight.
module decode_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst_in,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic        branch_taken,
  output logic        ctl_valid,
  output logic [1:0]  c_alu_a_sel,
  output logic        c_alu_b_sel,
  output logic [3:0]  c_alu_op,
  output logic [7:0]  c_flags_mask,
  output logic        c_new_sreg_sel,
  output logic        c_ex_out,
  output logic        c_branch_mode,
  output logic        c_pc_offset_mode,
  output logic [7:0]  imm_out,
  output logic [4:0]  rd_addr,
  output logic [4:0]  rr_addr,
  output logic        rd_we,
  output logic        sreg_we,
  output logic        pc_load,
  output logic        flush,
  output logic        illegal
);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_ADC    = 4'd1;
  localparam logic [3:0] OP_SUB    = 4'd2;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_OR     = 4'd5;
  localparam logic [3:0] OP_EOR    = 4'd6;
  localparam logic [3:0] OP_PASSB  = 4'd7;
  localparam logic [3:0] OP_BITSEL = 4'd15;

  // A set mask bit means the op leaves that SREG flag untouched.
  localparam logic [7:0] MASK_ARITH = 8'hC0;
  localparam logic [7:0] MASK_LOGIC = 8'hE1;
  localparam logic [7:0] MASK_NONE  = 8'hFF;

  localparam logic [15:0] INST_NOP = 16'h0000;
  localparam logic [15:0] INST_LPM = 16'h95C8;

  typedef enum logic [2:0] {ISSUE, LPM_ADDR, LPM_DATA, BR_RESOLVE, FLUSH} state_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] a_sel;
    logic       b_sel;
    logic [3:0] op;
    logic [7:0] mask;
    logic       new_sreg_sel;
    logic       ex_out;
    logic       branch_mode;
    logic       pc_offset_mode;
    logic [7:0] imm;
    logic [4:0] rd;
    logic [4:0] rr;
    logic       rd_we;
    logic       sreg_we;
    logic       pc_load;
    logic       flush;
    logic       illegal;
  } ctl_t;

  state_t state;
  state_t dec_next;
  ctl_t   ctl;
  ctl_t   dec;
  logic   is_rr;
  logic   is_imm;

  always_comb begin
    dec      = '0;
    dec.vld  = 1'b1;
    dec_next = ISSUE;
    is_rr    = 1'b0;
    is_imm   = 1'b0;
    case (inst_in[15:10])
      6'b000011: begin is_rr = 1'b1; dec.op = OP_ADD;   dec.mask = MASK_ARITH; dec.sreg_we = 1'b1; end
      6'b000111: begin is_rr = 1'b1; dec.op = OP_ADC;   dec.mask = MASK_ARITH; dec.sreg_we = 1'b1; end
      6'b000110: begin is_rr = 1'b1; dec.op = OP_SUB;   dec.mask = MASK_ARITH; dec.sreg_we = 1'b1; end
      6'b001000: begin is_rr = 1'b1; dec.op = OP_AND;   dec.mask = MASK_LOGIC; dec.sreg_we = 1'b1; end
      6'b001001: begin is_rr = 1'b1; dec.op = OP_EOR;   dec.mask = MASK_LOGIC; dec.sreg_we = 1'b1; end
      6'b001010: begin is_rr = 1'b1; dec.op = OP_OR;    dec.mask = MASK_LOGIC; dec.sreg_we = 1'b1; end
      6'b001011: begin is_rr = 1'b1; dec.op = OP_PASSB; dec.mask = MASK_NONE; end
      6'b111100, 6'b111101: begin
        // BRBS/BRBC: execute extracts SREG bit imm; bit 10 distinguishes clear from set.
        dec.a_sel       = 2'd1;
        dec.b_sel       = 1'b1;
        dec.op          = OP_BITSEL;
        dec.mask        = MASK_NONE;
        dec.imm         = {5'b00000, inst_in[2:0]};
        dec.branch_mode = ~inst_in[10];
        dec_next        = BR_RESOLVE;
      end
      default: begin
        case (inst_in[15:12])
          4'b1110: begin is_imm = 1'b1; dec.op = OP_PASSB; dec.mask = MASK_NONE;  dec.rd_we = 1'b1; end
          4'b0101: begin is_imm = 1'b1; dec.op = OP_SUB;   dec.mask = MASK_ARITH; dec.rd_we = 1'b1; dec.sreg_we = 1'b1; end
          4'b0011: begin is_imm = 1'b1; dec.op = OP_SUB;   dec.mask = MASK_ARITH; dec.sreg_we = 1'b1; end
          4'b1100: begin
            dec.pc_offset_mode = 1'b1;
            dec.pc_load        = 1'b1;
            dec.imm            = inst_in[7:0];
            dec_next           = FLUSH;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
    endcase

    if (is_rr) begin
      dec.rd           = inst_in[8:4];
      dec.rr           = {inst_in[9], inst_in[3:0]};
      dec.rd_we        = 1'b1;
      dec.ex_out       = 1'b1;
      dec.new_sreg_sel = 1'b1;
    end
    if (is_imm) begin
      dec.rd           = {1'b1, inst_in[7:4]};
      dec.imm          = {inst_in[11:8], inst_in[3:0]};
      dec.b_sel        = 1'b1;
      dec.ex_out       = 1'b1;
      dec.new_sreg_sel = 1'b1;
    end

    // Exact-match encodings override whatever the field decode above produced.
    if (inst_in == INST_NOP) begin
      dec      = '0;
      dec.vld  = 1'b1;
      dec_next = ISSUE;
    end else if (inst_in == INST_LPM) begin
      dec      = '0;
      dec_next = LPM_ADDR;
    end
  end

  // pc_load lands the cycle after branch resolve; the flush pulse follows one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ISSUE;
      ctl        <= '0;
      inst_ready <= 1'b1;
    end else begin
      ctl <= '0;
      case (state)
        ISSUE: begin
          if (inst_valid && inst_ready) begin
            ctl        <= dec;
            state      <= dec_next;
            inst_ready <= (dec_next == ISSUE);
          end else begin
            inst_ready <= 1'b1;
          end
        end
        LPM_ADDR: begin
          ctl.vld    <= 1'b1;
          ctl.mask   <= MASK_NONE;
          ctl.rd_we  <= 1'b1;
          state      <= LPM_DATA;
          inst_ready <= 1'b0;
        end
        LPM_DATA: begin
          state      <= ISSUE;
          inst_ready <= 1'b1;
        end
        BR_RESOLVE: begin
          if (branch_taken) begin
            ctl.pc_load <= 1'b1;
            state       <= FLUSH;
            inst_ready  <= 1'b0;
          end else begin
            state      <= ISSUE;
            inst_ready <= 1'b1;
          end
        end
        FLUSH: begin
          ctl.flush  <= 1'b1;
          state      <= ISSUE;
          inst_ready <= 1'b0;
        end
        default: begin
          state      <= ISSUE;
          inst_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ctl_valid        = ctl.vld;
  assign c_alu_a_sel      = ctl.a_sel;
  assign c_alu_b_sel      = ctl.b_sel;
  assign c_alu_op         = ctl.op;
  assign c_flags_mask     = ctl.mask;
  assign c_new_sreg_sel   = ctl.new_sreg_sel;
  assign c_ex_out         = ctl.ex_out;
  assign c_branch_mode    = ctl.branch_mode;
  assign c_pc_offset_mode = ctl.pc_offset_mode;
  assign imm_out          = ctl.imm;
  assign rd_addr          = ctl.rd;
  assign rr_addr          = ctl.rr;
  assign rd_we            = ctl.rd_we;
  assign sreg_we          = ctl.sreg_we;
  assign pc_load          = ctl.pc_load;
  assign flush            = ctl.flush;
  assign illegal          = ctl.illegal;

endmodule

// File: tb/tb_decode_seq.sv
// Directed bench for decode_seq: full control-word compare each cycle against hand-computed vectors.
module tb_decode_seq;

  logic        clk;
  logic        rst;
  logic [15:0] inst_in;
  logic        inst_valid;
  logic        inst_ready;
  logic        branch_taken;
  logic        ctl_valid;
  logic [1:0]  c_alu_a_sel;
  logic        c_alu_b_sel;
  logic [3:0]  c_alu_op;
  logic [7:0]  c_flags_mask;
  logic        c_new_sreg_sel;
  logic        c_ex_out;
  logic        c_branch_mode;
  logic        c_pc_offset_mode;
  logic [7:0]  imm_out;
  logic [4:0]  rd_addr;
  logic [4:0]  rr_addr;
  logic        rd_we;
  logic        sreg_we;
  logic        pc_load;
  logic        flush;
  logic        illegal;

  int n_checks = 0;
  int n_pass   = 0;

  decode_seq dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .branch_taken(branch_taken), .ctl_valid(ctl_valid), .c_alu_a_sel(c_alu_a_sel),
    .c_alu_b_sel(c_alu_b_sel), .c_alu_op(c_alu_op), .c_flags_mask(c_flags_mask),
    .c_new_sreg_sel(c_new_sreg_sel), .c_ex_out(c_ex_out), .c_branch_mode(c_branch_mode),
    .c_pc_offset_mode(c_pc_offset_mode), .imm_out(imm_out), .rd_addr(rd_addr), .rr_addr(rr_addr),
    .rd_we(rd_we), .sreg_we(sreg_we), .pc_load(pc_load), .flush(flush), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [43:0] obs;
  assign obs = {ctl_valid, c_alu_a_sel, c_alu_b_sel, c_alu_op, c_flags_mask, c_new_sreg_sel,
                c_ex_out, c_branch_mode, c_pc_offset_mode, imm_out, rd_addr, rr_addr,
                rd_we, sreg_we, pc_load, flush, illegal, inst_ready};

  function automatic logic [43:0] mk(
    input logic v, input logic [1:0] a, input logic b, input logic [3:0] op, input logic [7:0] m,
    input logic nss, input logic exo, input logic brm, input logic pco, input logic [7:0] imm,
    input logic [4:0] rd, input logic [4:0] rr, input logic rdwe, input logic srwe,
    input logic pcl, input logic fl, input logic ill, input logic rdy);
    return {v, a, b, op, m, nss, exo, brm, pco, imm, rd, rr, rdwe, srwe, pcl, fl, ill, rdy};
  endfunction

  task automatic check(input string tag, input logic [43:0] got, input logic [43:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reg-reg table: word, op, mask, rd, rr, sreg_we
  logic [15:0] rr_w    [7] = '{16'h0D34, 16'h1C12, 16'h1B01, 16'h2012, 16'h25F0, 16'h2889, 16'h2E5F};
  logic [3:0]  rr_op   [7] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd5, 4'd7};
  logic [7:0]  rr_mask [7] = '{8'hC0, 8'hC0, 8'hC0, 8'hE1, 8'hE1, 8'hE1, 8'hFF};
  logic [4:0]  rr_rd   [7] = '{5'd19, 5'd1, 5'd16, 5'd1, 5'd31, 5'd8, 5'd5};
  logic [4:0]  rr_rr   [7] = '{5'd4, 5'd2, 5'd17, 5'd2, 5'd0, 5'd9, 5'd31};
  logic        rr_sw   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  // Immediate table (LDI, SUBI, CPI): word, op, mask, rd, imm, rd_we, sreg_we
  logic [15:0] im_w    [3] = '{16'hEA15, 16'h5140, 16'h330C};
  logic [3:0]  im_op   [3] = '{4'd7, 4'd2, 4'd2};
  logic [7:0]  im_mask [3] = '{8'hFF, 8'hC0, 8'hC0};
  logic [4:0]  im_rd   [3] = '{5'd17, 5'd20, 5'd16};
  logic [7:0]  im_imm  [3] = '{8'hA5, 8'h10, 8'h3C};
  logic        im_rw   [3] = '{1'b1, 1'b1, 1'b0};
  logic        im_sw   [3] = '{1'b0, 1'b1, 1'b1};

  logic [43:0] idle_rdy;
  logic [43:0] add_r3;

  initial begin
    idle_rdy = mk(0,0,0,0,8'h00,0,0,0,0,8'h00,0,0,0,0,0,0,0,1);
    add_r3   = mk(1,0,0,0,8'hC0,1,1,0,0,8'h00,5'd3,5'd20,1,1,0,0,0,1);

    rst = 1'b1; inst_in = 16'h0E34; inst_valid = 1'b1; branch_taken = 1'b0;
    repeat (2) step();
    check("reset_state", obs, idle_rdy);

    // First edge after release accepts ADD r3,r20.
    rst = 1'b0;
    step();
    check("add_r3_r20", obs, add_r3);

    for (int i = 0; i < 7; i++) begin
      inst_in = rr_w[i];
      step();
      check($sformatf("rr_%0d", i), obs,
            mk(1,0,0,rr_op[i],rr_mask[i],1,1,0,0,8'h00,rr_rd[i],rr_rr[i],1,rr_sw[i],0,0,0,1));
    end

    for (int i = 0; i < 3; i++) begin
      inst_in = im_w[i];
      step();
      check($sformatf("imm_%0d", i), obs,
            mk(1,0,1,im_op[i],im_mask[i],1,1,0,0,im_imm[i],im_rd[i],5'd0,im_rw[i],im_sw[i],0,0,0,1));
    end

    inst_in = 16'h0000;
    step();
    check("nop", obs, mk(1,0,0,0,8'h00,0,0,0,0,8'h00,0,0,0,0,0,0,0,1));

    inst_in = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("illegal_%0d", i), obs, mk(1,0,0,0,8'h00,0,0,0,0,8'h00,0,0,0,0,0,0,1,1));
    end

    inst_valid = 1'b0;
    step();
    check("idle_hold", obs, idle_rdy);

    // RJMP with an ADD held valid behind it: the ADD waits out pc_load and flush.
    inst_in = 16'hC005; inst_valid = 1'b1;
    step();
    check("rjmp_issue", obs, mk(1,0,0,0,8'h00,0,0,0,1,8'h05,0,0,0,0,1,0,0,0));
    inst_in = 16'h0E34;
    step();
    check("rjmp_flush", obs, mk(0,0,0,0,8'h00,0,0,0,0,8'h00,0,0,0,0,0,1,0,0));
    step();
    check("rjmp_resume", obs, idle_rdy);
    step();
    check("rjmp_next_add", obs, add_r3);
    inst_valid = 1'b0;

    // BRBS bit 1, taken.
    inst_in = 16'hF001; inst_valid = 1'b1; branch_taken = 1'b1;
    step();
    check("brbs_t_issue", obs, mk(1,2'd1,1,4'd15,8'hFF,0,0,1,0,8'h01,0,0,0,0,0,0,0,0));
    inst_valid = 1'b0;
    step();
    check("brbs_t_pcload", obs, mk(0,0,0,0,8'h00,0,0,0,0,8'h00,0,0,0,0,1,0,0,0));
    branch_taken = 1'b0;
    step();
    check("brbs_t_flush", obs, mk(0,0,0,0,8'h00,0,0,0,0,8'h00,0,0,0,0,0,1,0,0));
    step();
    check("brbs_t_resume", obs, idle_rdy);

    // BRBS bit 1, not taken: no pc_load, no flush.
    inst_in = 16'hF001; inst_valid = 1'b1;
    step();
    check("brbs_nt_issue", obs, mk(1,2'd1,1,4'd15,8'hFF,0,0,1,0,8'h01,0,0,0,0,0,0,0,0));
    inst_valid = 1'b0;
    step();
    check("brbs_nt_resume", obs, idle_rdy);
    step();
    check("brbs_nt_noflush", obs, idle_rdy);

    // BRBC bit 5, not taken.
    inst_in = 16'hF405; inst_valid = 1'b1;
    step();
    check("brbc_issue", obs, mk(1,2'd1,1,4'd15,8'hFF,0,0,0,0,8'h05,0,0,0,0,0,0,0,0));
    inst_valid = 1'b0;
    step();
    check("brbc_resume", obs, idle_rdy);

    // LPM: ready low two cycles, register write on the second.
    inst_in = 16'h95C8; inst_valid = 1'b1;
    step();
    check("lpm_addr", obs, mk(0,0,0,0,8'h00,0,0,0,0,8'h00,0,0,0,0,0,0,0,0));
    inst_valid = 1'b0;
    step();
    check("lpm_data", obs, mk(1,0,0,0,8'hFF,0,0,0,0,8'h00,0,0,1,0,0,0,0,0));
    step();
    check("lpm_resume", obs, idle_rdy);

    // Reset during LPM_ADDR abandons the load with no write.
    inst_in = 16'h95C8; inst_valid = 1'b1;
    step();
    check("lpm2_addr", obs, mk(0,0,0,0,8'h00,0,0,0,0,8'h00,0,0,0,0,0,0,0,0));
    inst_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("lpm_rst_async", obs, idle_rdy);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("lpm_rst_after_%0d", i), obs, idle_rdy);
    end

    inst_in = 16'h0E34; inst_valid = 1'b1;
    step();
    check("post_rst_add", obs, add_r3);
    inst_valid = 1'b0;
    step();
    check("final_idle", obs, idle_rdy);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
